// File: rtl/alu.sv
// 8-bit ALU with a one-cycle registered result and {Z,C,S,O} status flags.
// Result and flags are formed combinationally and captured on every rising clock edge.
module alu (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] Operand1,
  input  logic [7:0] Operand2,
  input  logic [3:0] Mode,
  output logic [7:0] Out,
  output logic [3:0] Flags
);

  localparam int unsigned DataW = 8;
  localparam int unsigned FlagW = 4;
  localparam int unsigned ProdW = 2 * DataW;

  typedef enum logic [3:0] {
    MODE_ADD = 4'b0000,
    MODE_SUB = 4'b0001,
    MODE_INC = 4'b0010,
    MODE_DEC = 4'b0011,
    MODE_AND = 4'b0100,
    MODE_OR  = 4'b0101,
    MODE_XOR = 4'b0110,
    MODE_NOT = 4'b0111,
    MODE_SHL = 4'b1000,
    MODE_SHR = 4'b1001,
    MODE_ASR = 4'b1010,
    MODE_ROL = 4'b1011,
    MODE_ROR = 4'b1100,
    MODE_NOR = 4'b1101,
    MODE_CMP = 4'b1110,
    MODE_MUL = 4'b1111
  } mode_e;

  logic [DataW-1:0] out_d, out_q;
  logic [FlagW-1:0] flags_d, flags_q;

  logic [DataW-1:0] a, b;
  logic [DataW:0]   sum9, diff9, inc9, dec9;
  logic [ProdW-1:0] prod;
  logic             add_ovf, sub_ovf, inc_ovf, dec_ovf;
  logic [DataW-1:0] res, flag_src;
  logic             c_flag, o_flag;

  assign a = Operand1;
  assign b = Operand2;

  // Shared arithmetic datapaths; bit 8 is carry (add) or borrow (subtract).
  always_comb begin
    sum9  = {1'b0, a} + {1'b0, b};
    diff9 = {1'b0, a} - {1'b0, b};
    inc9  = {1'b0, a} + (DataW+1)'(1);
    dec9  = {1'b0, a} - (DataW+1)'(1);
    prod  = ProdW'(a) * ProdW'(b);
    add_ovf = (a[7] == b[7]) && (sum9[7] != a[7]);
    sub_ovf = (a[7] != b[7]) && (diff9[7] != a[7]);
    inc_ovf = !a[7] && inc9[7];
    dec_ovf = a[7] && !dec9[7];
  end

  // Result/flag select; CMP keeps A on Out but takes its flags from A-B.
  always_comb begin
    res      = '0;
    flag_src = '0;
    c_flag   = 1'b0;
    o_flag   = 1'b0;
    unique case (mode_e'(Mode))
      MODE_ADD: begin
        res    = sum9[DataW-1:0];
        c_flag = sum9[DataW];
        o_flag = add_ovf;
      end
      MODE_SUB: begin
        res    = diff9[DataW-1:0];
        c_flag = diff9[DataW];
        o_flag = sub_ovf;
      end
      MODE_INC: begin
        res    = inc9[DataW-1:0];
        c_flag = inc9[DataW];
        o_flag = inc_ovf;
      end
      MODE_DEC: begin
        res    = dec9[DataW-1:0];
        c_flag = dec9[DataW];
        o_flag = dec_ovf;
      end
      MODE_AND: res = a & b;
      MODE_OR:  res = a | b;
      MODE_XOR: res = a ^ b;
      MODE_NOT: res = ~a;
      MODE_SHL: begin
        res    = {a[6:0], 1'b0};
        c_flag = a[7];
        o_flag = a[7] ^ a[6];
      end
      MODE_SHR: begin
        res    = {1'b0, a[7:1]};
        c_flag = a[0];
      end
      MODE_ASR: begin
        res    = {a[7], a[7:1]};
        c_flag = a[0];
      end
      MODE_ROL: begin
        res    = {a[6:0], a[7]};
        c_flag = a[7];
      end
      MODE_ROR: begin
        res    = {a[0], a[7:1]};
        c_flag = a[0];
      end
      MODE_NOR: res = ~(a | b);
      MODE_CMP: begin
        res    = a;
        c_flag = diff9[DataW];
        o_flag = sub_ovf;
      end
      MODE_MUL: begin
        res    = prod[DataW-1:0];
        c_flag = |prod[ProdW-1:DataW];
        o_flag = |prod[ProdW-1:DataW];
      end
      default: res = '0;
    endcase
    flag_src = (mode_e'(Mode) == MODE_CMP) ? diff9[DataW-1:0] : res;
  end

  always_comb begin
    out_d   = res;
    flags_d = {(flag_src == '0), c_flag, flag_src[DataW-1], o_flag};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  assign Out   = out_q;
  assign Flags = flags_q;

endmodule

// File: tb/tb_alu.sv
// Directed table-driven bench for the 8-bit ALU plus reset and hold sequences.
module tb_alu;

  logic       clock;
  logic       reset_n;
  logic [7:0] Operand1;
  logic [7:0] Operand2;
  logic [3:0] Mode;
  logic [7:0] Out;
  logic [3:0] Flags;

  int tests_run;
  int tests_failed;

  typedef struct {
    string      name;
    logic [3:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_out;
    logic [3:0] exp_flags;
  } vec_t;

  vec_t vecs[$];

  alu dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Mode     (Mode),
    .Out      (Out),
    .Flags    (Flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] got_o, input logic [7:0] exp_o,
                       input logic [3:0] got_f, input logic [3:0] exp_f);
    tests_run++;
    if (got_o !== exp_o || got_f !== exp_f) begin
      tests_failed++;
      $display("FAIL %s: Out=%02h Flags=%04b, expected Out=%02h Flags=%04b",
               name, got_o, got_f, exp_o, exp_f);
    end
  endtask

  task automatic add_vec(input string n, input logic [3:0] m, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] eo, input logic [3:0] ef);
    vec_t v;
    v.name = n; v.mode = m; v.a = a; v.b = b; v.exp_out = eo; v.exp_flags = ef;
    vecs.push_back(v);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    add_vec("sweep_add", 4'b0000, 8'h04, 8'h02, 8'h06, 4'b0000);
    add_vec("sweep_sub", 4'b0001, 8'h04, 8'h02, 8'h02, 4'b0000);
    add_vec("sweep_inc", 4'b0010, 8'h04, 8'h02, 8'h05, 4'b0000);
    add_vec("sweep_dec", 4'b0011, 8'h04, 8'h02, 8'h03, 4'b0000);
    add_vec("sweep_and", 4'b0100, 8'h04, 8'h02, 8'h00, 4'b1000);
    add_vec("sweep_or",  4'b0101, 8'h04, 8'h02, 8'h06, 4'b0000);
    add_vec("sweep_xor", 4'b0110, 8'h04, 8'h02, 8'h06, 4'b0000);
    add_vec("sweep_not", 4'b0111, 8'h04, 8'h02, 8'hFB, 4'b0010);
    add_vec("sweep_shl", 4'b1000, 8'h04, 8'h02, 8'h08, 4'b0000);
    add_vec("sweep_shr", 4'b1001, 8'h04, 8'h02, 8'h02, 4'b0000);
    add_vec("sweep_asr", 4'b1010, 8'h04, 8'h02, 8'h02, 4'b0000);
    add_vec("sweep_rol", 4'b1011, 8'h04, 8'h02, 8'h08, 4'b0000);
    add_vec("sweep_ror", 4'b1100, 8'h04, 8'h02, 8'h02, 4'b0000);
    add_vec("sweep_nor", 4'b1101, 8'h04, 8'h02, 8'hF9, 4'b0010);
    add_vec("sweep_cmp", 4'b1110, 8'h04, 8'h02, 8'h04, 4'b0000);
    add_vec("sweep_mul", 4'b1111, 8'h04, 8'h02, 8'h08, 4'b0000);
    add_vec("add_wrap",  4'b0000, 8'hFF, 8'h01, 8'h00, 4'b1100);
    add_vec("add_ovf",   4'b0000, 8'h7F, 8'h01, 8'h80, 4'b0011);
    add_vec("sub_borrow",4'b0001, 8'h02, 8'h04, 8'hFE, 4'b0110);
    add_vec("cmp_equal", 4'b1110, 8'h05, 8'h05, 8'h05, 4'b1000);
    add_vec("ror_edge",  4'b1100, 8'h01, 8'h00, 8'h80, 4'b0110);
    add_vec("asr_edge",  4'b1010, 8'h80, 8'h00, 8'hC0, 4'b0010);
    add_vec("shl_edge",  4'b1000, 8'h40, 8'h00, 8'h80, 4'b0011);
    add_vec("mul_ovf",   4'b1111, 8'h10, 8'h10, 8'h00, 4'b1101);
    add_vec("mul_fit",   4'b1111, 8'h0F, 8'h11, 8'hFF, 4'b0010);
    add_vec("inc_wrap",  4'b0010, 8'hFF, 8'h00, 8'h00, 4'b1100);
    add_vec("dec_borrow",4'b0011, 8'h00, 8'h00, 8'hFF, 4'b0110);
    add_vec("inc_ovf",   4'b0010, 8'h7F, 8'h00, 8'h80, 4'b0011);
    add_vec("cmp_lt_ovf",4'b1110, 8'h80, 8'h01, 8'h80, 4'b0001);

    // Reset held with ADD 4+2 applied: outputs forced to zero regardless of clock.
    reset_n  = 1'b0;
    Operand1 = 8'h04;
    Operand2 = 8'h02;
    Mode     = 4'b0000;
    #1;
    check("reset_async", Out, 8'h00, Flags, 4'b0000);
    repeat (2) @(posedge clock);
    #1;
    check("reset_held", Out, 8'h00, Flags, 4'b0000);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("release_pre_edge", Out, 8'h00, Flags, 4'b0000);
    @(posedge clock);
    #1;
    check("release_first_edge", Out, 8'h06, Flags, 4'b0000);

    foreach (vecs[i]) begin
      @(negedge clock);
      Mode     = vecs[i].mode;
      Operand1 = vecs[i].a;
      Operand2 = vecs[i].b;
      @(posedge clock);
      #1;
      check(vecs[i].name, Out, vecs[i].exp_out, Flags, vecs[i].exp_flags);
    end

    // Inputs changed between edges must not reach the outputs early.
    @(negedge clock);
    Mode = 4'b0000; Operand1 = 8'h04; Operand2 = 8'h02;
    @(posedge clock);
    #1;
    check("hold_load", Out, 8'h06, Flags, 4'b0000);
    @(negedge clock);
    Mode = 4'b0001; Operand1 = 8'h02; Operand2 = 8'h04;
    #1;
    check("hold_between_edges", Out, 8'h06, Flags, 4'b0000);
    @(posedge clock);
    #1;
    check("hold_next_edge", Out, 8'hFE, Flags, 4'b0110);

    // Mid-operation reset clears outputs immediately, not at the next edge.
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midop_reset", Out, 8'h00, Flags, 4'b0000);
    @(negedge clock);
    Mode = 4'b1111; Operand1 = 8'h10; Operand2 = 8'h10;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("midop_release", Out, 8'h00, Flags, 4'b1101);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
